// File: rtl/mux4_1_classic_pkg.sv
// mux4_1_classic_pkg: shared constants for the classic 4:1 mux slice.
// Holds the select encodings used by the decoder, the top level and the bench.
// No ports; import with `import mux4_1_classic_pkg::*;`.
package mux4_1_classic_pkg;

  // Number of data inputs steered by the mux (width of the one-hot select).
  localparam int NUM_INPUTS = 4;

  // Select encodings: S value that routes each data input to F.
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

endpackage

// File: rtl/mux4_1_classic_if.sv
// mux4_1_classic_if: bundles the mux data/select bus.
// master drives S, A..D and observes F, sel_onehot; slave is the mux side.
// WIDTH sets the width of A, B, C, D and F.
interface mux4_1_classic_if #(
  parameter int WIDTH = 1
);
  import mux4_1_classic_pkg::*;

  logic [1:0]            S;
  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  logic [WIDTH-1:0]      C;
  logic [WIDTH-1:0]      D;
  logic [WIDTH-1:0]      F;
  logic [NUM_INPUTS-1:0] sel_onehot;

  modport master (
    output S, A, B, C, D,
    input  F, sel_onehot
  );

  modport slave (
    input  S, A, B, C, D,
    output F, sel_onehot
  );

endinterface

// File: rtl/mux4_1_classic_dec2_4.sv
// mux4_1_classic_dec2_4: gate-level 2-to-4 select decoder.
// Ports: s (2-bit select in), y (4-bit one-hot out, y[i] high when s == i).
// Purely combinational; exactly one output high for any known s.
module mux4_1_classic_dec2_4
  import mux4_1_classic_pkg::*;
(
  input  logic [1:0]            s,
  output logic [NUM_INPUTS-1:0] y
);

  logic s0_n;
  logic s1_n;

  assign s0_n = ~s[0];
  assign s1_n = ~s[1];

  assign y[0] = s1_n & s0_n;
  assign y[1] = s1_n & s[0];
  assign y[2] = s[1] & s0_n;
  assign y[3] = s[1] & s[0];

endmodule

// File: rtl/mux4_1_classic.sv
// mux4_1_classic: 4:1 mux in classic decoder + AND-OR gate form.
// Ports: clk, rst_n (async active-low, output register only), bus (slave: S, A..D in; F, sel_onehot out).
// Build option MUX4_1_CLASSIC_OUTREG_EN: when defined F comes from a flop (1-cycle latency, async clear to 0);
// otherwise F is combinational. sel_onehot is combinational in both builds.
module mux4_1_classic
  import mux4_1_classic_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_1_classic_if.slave       bus
);

  logic [NUM_INPUTS-1:0] sel_onehot;
  logic [WIDTH-1:0]      f_comb;

  mux4_1_classic_dec2_4 u_dec2_4 (
    .s (bus.S),
    .y (sel_onehot)
  );

  assign bus.sel_onehot = sel_onehot;

  // AND-OR plane: each decoded select bit is replicated across the data
  // width to gate its input, then the four gated terms are ORed. Because
  // the decoder is one-hot, unselected inputs contribute all zeros.
  assign f_comb = (bus.A & {WIDTH{sel_onehot[0]}})
                | (bus.B & {WIDTH{sel_onehot[1]}})
                | (bus.C & {WIDTH{sel_onehot[2]}})
                | (bus.D & {WIDTH{sel_onehot[3]}});

`ifdef MUX4_1_CLASSIC_OUTREG_EN
  logic [WIDTH-1:0] f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= '0;
    end else begin
      f_q <= f_comb;
    end
  end

  assign bus.F = f_q;
`else
  // clk and rst_n exist only so both builds share one port list.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign bus.F = f_comb;
`endif

endmodule

// File: tb/tb_mux4_1_classic.sv
// tb_mux4_1_classic: self-checking bench for mux4_1_classic (WIDTH=1).
// Expected F/sel_onehot pushed to a scoreboard queue on each drive, popped and compared once the DUT output is due.
// Also covers the registered build (MUX4_1_CLASSIC_OUTREG_EN): reset hold, 1-edge latency, async reset.
module tb_mux4_1_classic;
  import mux4_1_classic_pkg::*;

  typedef struct packed {
    logic       f;
    logic [3:0] oh;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];

  mux4_1_classic_if #(.WIDTH(1)) bus ();

  mux4_1_classic #(.WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference one-hot for a select value, written as a lookup on the
  // package encodings.
  function automatic logic [3:0] ref_onehot(input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    case (s)
      SEL_A:   r = 4'b0001;
      SEL_B:   r = 4'b0010;
      SEL_C:   r = 4'b0100;
      SEL_D:   r = 4'b1000;
      default: r = 4'bxxxx;
    endcase
    return r;
  endfunction

  // Wait until the DUT output for the current inputs is valid.
  task automatic settle();
`ifdef MUX4_1_CLASSIC_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_F"}, {31'd0, bus.F}, {31'd0, e.f});
      check({tag, "_onehot"}, {28'd0, bus.sel_onehot}, {28'd0, e.oh});
    end
  endtask

  task automatic drive(input string tag, input logic [1:0] s,
                       input logic a, input logic b, input logic c, input logic d,
                       input logic exp_f);
    exp_t e;
    bus.S = s;
    bus.A = a;
    bus.B = b;
    bus.C = c;
    bus.D = d;
    e.f  = exp_f;
    e.oh = ref_onehot(s);
    sb.push_back(e);
    settle();
    pop_and_check(tag);
  endtask

  initial begin
    logic [3:0] vals;
    exp_t       e;

    bus.S = SEL_A;
    bus.A = 1'b0;
    bus.B = 1'b0;
    bus.C = 1'b0;
    bus.D = 1'b0;

`ifdef MUX4_1_CLASSIC_OUTREG_EN
    // Hold reset across clock edges with the selected input high: F must stay 0.
    bus.A = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_F", {31'd0, bus.F}, 32'd0);
    check("reset_onehot", {28'd0, bus.sel_onehot}, 32'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 1'b0;
    bus.S = SEL_B;
    bus.B = 1'b1;
    e.f  = 1'b1;
    e.oh = ref_onehot(SEL_B);
    sb.push_back(e);
    #1;
    check("latency_pre_edge_F", {31'd0, bus.F}, 32'd0);
    @(posedge clk);
    #1;
    pop_and_check("latency_one_edge");
    bus.B = 1'b0;
`else
    #1;
    check("reset_F", {31'd0, bus.F}, 32'd0);
    check("reset_onehot", {28'd0, bus.sel_onehot}, 32'b0001);
    #2;
    rst_n = 1'b1;
`endif

    drive("all_zero_selA",    SEL_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive("selA_A1",          SEL_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive("selB_AB1",         SEL_B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive("selC_unsel_high",  SEL_C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("selC_C1",          SEL_C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive("selD_all1",        SEL_D, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive("selA_all0",        SEL_A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Walking one: only input k is high; F is 1 only when k is the selected input.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        vals = 4'b0001 << k;
        drive($sformatf("walk_s%0d_in%0d", s, k), s[1:0],
              vals[0], vals[1], vals[2], vals[3], (s == k));
      end
    end

`ifdef MUX4_1_CLASSIC_OUTREG_EN
    // Leave F at 1, then drop reset between edges: F must clear before the next edge.
    drive("pre_async_reset", SEL_D, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_F", {31'd0, bus.F}, 32'd0);
    @(posedge clk);
    #1;
    check("async_reset_hold_F", {31'd0, bus.F}, 32'd0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
